clkgen_dff_unit: RTL and testbench
==================================

Name: clkgen_dff_unit

Overview:
- Single-clock block combining a burst clock generator with a D flip-flop.
- On a start request it produces N periods of a divided clock, gen_clk, derived from the system clock.
- Input d is captured into q at every rising edge of gen_clk.
- Used as a stimulus/sampling primitive: it drives a slow, countable clock and provides a register clocked by it, implemented fully synchronously in the clk domain.

Parameters:
- N, 10, number of gen_clk periods per burst (N >= 1).
- HALF_PERIOD, 5, clk cycles per gen_clk half-period (>= 1); the gen_clk period is 2*HALF_PERIOD clk cycles.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a burst; sampled only in IDLE.
- stop  input  1  abort the current burst.
- d  input  1  flip-flop data input.
- gen_clk  output  1  generated clock, registered.
- q  output  1  flip-flop output.
- busy  output  1  high while a burst is running.
- done  output  1  one-cycle pulse when a burst completes normally.
- pulse_count  output  ceil(log2(N+1))  number of gen_clk rising edges in the current/last burst.

Behaviour:
- Reset (rst_n=0, asynchronous, immediate): gen_clk=0, q=0, busy=0, done=0, pulse_count=0, state=IDLE, phase counter=0.
- States: IDLE, HIGH, LOW.
- IDLE:
  - gen_clk=0, busy=0.
  - On an edge with start=1 and stop=0: enter HIGH and perform a rise tick.
  - start=1 together with stop=1: stay in IDLE.
- Rise tick (same clk edge):
  - gen_clk <= 1.
  - q <= d, sampling d as seen just before that edge.
  - pulse_count <= pulse_count+1 (set to 1 on the first tick of a burst).
  - busy <= 1.
- HIGH: gen_clk stays 1 for exactly HALF_PERIOD clk cycles, then gen_clk <= 0 and the state moves to LOW.
- LOW: gen_clk stays 0 for HALF_PERIOD cycles. At the end of the phase:
  - If pulse_count < N: enter HIGH with a rise tick.
  - Else: enter IDLE with busy <= 0 and done <= 1 for exactly one cycle.
- Burst timing:
  - A full burst lasts 2*N*HALF_PERIOD clk cycles, from the start edge to the edge at which busy falls.
  - gen_clk has 50% duty cycle and no glitches.
- q:
  - Changes only on rise ticks; holds otherwise, including in IDLE and after stop.
  - Changes of d between rise ticks never affect q.
- stop=1 in HIGH or LOW:
  - Next edge: gen_clk <= 0, busy <= 0, state IDLE, done stays 0.
  - pulse_count and q keep their values.
  - stop has priority over phase-end transitions on the same edge.
- start while busy=1 is ignored; no restart and no counter effect.
- pulse_count is cleared to 0 only by reset. A new burst loads it with 1 on its first tick.
- done is 0 in every cycle except the single completion cycle.
- Reset asserted mid-burst aborts immediately; a start after release begins a fresh burst.

Test Plan:
- Reset: drive rst_n=0 asynchronously mid-cycle with q=1 and gen_clk=1 -> all outputs go to 0 without waiting for clk; they stay 0 until release.
- Nominal burst (N=10, HALF_PERIOD=5): one-cycle start; d updated once per gen_clk period to bit 1 of the loop index, i.e. sequence 0,0,1,1,0,0,1,1,0,0 -> gen_clk shows 10 periods of 10 clk cycles each; q follows that sequence at each rise; pulse_count steps 1..10; busy high for 100 cycles; then done=1 for 1 cycle.
- Data isolation: toggle d every clk cycle while gen_clk is high or low -> q changes only on rise-tick edges and equals d sampled at those edges.
- Abort: assert stop during the 4th HIGH phase -> gen_clk=0, busy=0 on the next edge; pulse_count=4; q unchanged; done never asserts.
- Start handling:
  - start pulsed during a burst -> burst length is still exactly 100 cycles.
  - start=stop=1 in IDLE -> busy stays 0, gen_clk stays 0.
- Reset mid-burst then restart: rst_n low at pulse 6, release, start -> a fresh burst with pulse_count 1..10 and done at the end.

Source files
------------

// File: rtl/clkgen_dff_unit.sv
// -----------------------------------------------------------------------------
// clkgen_dff_unit
//
// Purpose:
//   Burst clock generator combined with a D flip-flop. A start request in IDLE
//   launches a burst of N periods of a divided clock (gen_clk). Each gen_clk
//   period is 2*HALF_PERIOD clk cycles long with a 50% duty cycle. Input d is
//   captured into q at every gen_clk rising edge ("rise tick"). Everything is
//   implemented synchronously in the clk domain: gen_clk is a registered data
//   signal, not a derived clock.
//
// Ports:
//   clk         in   system clock; all state changes on its rising edge
//   rst_n       in   asynchronous active-low reset
//   start       in   burst request, honoured only in IDLE (and only if stop=0)
//   stop        in   abort the running burst (priority over phase ends)
//   d           in   flip-flop data input, sampled on rise ticks only
//   gen_clk     out  generated clock (registered, glitch-free)
//   q           out  flip-flop output
//   busy        out  high while a burst is running
//   done        out  one-cycle pulse when a burst completes normally
//   pulse_count out  gen_clk rising edges in the current/last burst
// -----------------------------------------------------------------------------
module clkgen_dff_unit #(
    parameter  int N           = 10,
    parameter  int HALF_PERIOD = 5,
    localparam int CW          = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          stop,
    input  logic          d,
    output logic          gen_clk,
    output logic          q,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] pulse_count
);

    // Phase counter needs at least one bit even when HALF_PERIOD == 1.
    localparam int             PW         = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam logic [PW-1:0]  PHASE_LAST = PW'(HALF_PERIOD - 1);
    localparam logic [CW-1:0]  N_C        = CW'(N);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HIGH,
        S_LOW
    } state_t;

    state_t          state_q,   state_d;
    logic [PW-1:0]   phase_q,   phase_d;
    logic            gen_clk_q, gen_clk_d;
    logic            dff_q,     dff_d;
    logic            busy_q,    busy_d;
    logic            done_q,    done_d;
    logic [CW-1:0]   pcnt_q,    pcnt_d;
    logic            phase_end;

    assign phase_end = (phase_q == PHASE_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            phase_q   <= '0;
            gen_clk_q <= 1'b0;
            dff_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            gen_clk_q <= gen_clk_d;
            dff_q     <= dff_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pcnt_q    <= pcnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        gen_clk_d = gen_clk_q;
        dff_d     = dff_q;
        busy_d    = busy_q;
        done_d    = 1'b0;          // done is a single-cycle pulse
        pcnt_d    = pcnt_q;

        case (state_q)
            S_IDLE: begin
                gen_clk_d = 1'b0;
                busy_d    = 1'b0;
                phase_d   = '0;
                // start together with stop is treated as "no request".
                if (start && !stop) begin
                    state_d   = S_HIGH;
                    gen_clk_d = 1'b1;
                    dff_d     = d;
                    pcnt_d    = CW'(1);    // first tick of a fresh burst
                    busy_d    = 1'b1;
                end
            end

            S_HIGH: begin
                if (stop) begin
                    state_d   = S_IDLE;
                    gen_clk_d = 1'b0;
                    busy_d    = 1'b0;
                    phase_d   = '0;
                end else if (phase_end) begin
                    state_d   = S_LOW;
                    gen_clk_d = 1'b0;
                    phase_d   = '0;
                end else begin
                    phase_d   = phase_q + PW'(1);
                end
            end

            S_LOW: begin
                if (stop) begin
                    state_d   = S_IDLE;
                    gen_clk_d = 1'b0;
                    busy_d    = 1'b0;
                    phase_d   = '0;
                end else if (phase_end) begin
                    phase_d = '0;
                    if (pcnt_q < N_C) begin
                        // Rise tick: next gen_clk period starts on this edge.
                        state_d   = S_HIGH;
                        gen_clk_d = 1'b1;
                        dff_d     = d;
                        pcnt_d    = pcnt_q + CW'(1);
                    end else begin
                        state_d   = S_IDLE;
                        busy_d    = 1'b0;
                        done_d    = 1'b1;
                    end
                end else begin
                    phase_d = phase_q + PW'(1);
                end
            end

            default: begin
                state_d   = S_IDLE;
                gen_clk_d = 1'b0;
                busy_d    = 1'b0;
                phase_d   = '0;
            end
        endcase
    end

    assign gen_clk     = gen_clk_q;
    assign q           = dff_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign pulse_count = pcnt_q;

endmodule

// File: tb/tb_clkgen_dff_unit.sv
// -----------------------------------------------------------------------------
// tb_clkgen_dff_unit
//
// Directed, table-driven bench for clkgen_dff_unit with N=10, HALF_PERIOD=5.
// Burst tables hold the d value applied for each rise tick together with the
// hand-computed q and pulse_count expected right after that tick. Abort,
// start/stop in IDLE and reset scenarios are hand-written sequences.
// Inputs change and outputs are sampled 1 ns after each rising clk edge.
// -----------------------------------------------------------------------------
module tb_clkgen_dff_unit;

    localparam int N  = 10;
    localparam int H  = 5;
    localparam int CW = $clog2(N + 1);

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          stop;
    logic          d;
    logic          gen_clk;
    logic          q;
    logic          busy;
    logic          done;
    logic [CW-1:0] pulse_count;

    int checks;
    int fails;

    clkgen_dff_unit #(
        .N           (N),
        .HALF_PERIOD (H)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .stop        (stop),
        .d           (d),
        .gen_clk     (gen_clk),
        .q           (q),
        .busy        (busy),
        .done        (done),
        .pulse_count (pulse_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic d;        // d presented at the rise tick
        logic exp_q;    // q right after that tick
        int   exp_pc;   // pulse_count right after that tick
    } vec_t;

    vec_t nom[10];
    vec_t alt[10];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t tab(input bit use_alt, input int i);
        return use_alt ? alt[i] : nom[i];
    endfunction

    // One full burst driven from IDLE. With use_alt, d is toggled on every
    // non-tick cycle (only the value just before each tick may reach q) and a
    // stray start is pulsed mid-burst, which must not disturb the timing.
    task automatic run_burst(input bit use_alt);
        vec_t cur;
        vec_t nxt;
        cur   = tab(use_alt, 0);
        d     = cur.d;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int p = 0; p < N; p++) begin
            cur = tab(use_alt, p);
            nxt = (p < N - 1) ? tab(use_alt, p + 1) : '{1'b0, 1'b0, 0};
            chk($sformatf("rise%0d gen_clk", p), int'(gen_clk), 1);
            chk($sformatf("rise%0d q", p), int'(q), int'(cur.exp_q));
            chk($sformatf("rise%0d pulse_count", p), int'(pulse_count), cur.exp_pc);
            chk($sformatf("rise%0d busy", p), int'(busy), 1);
            d = use_alt ? ~d : nxt.d;
            for (int k = 1; k < 2 * H; k++) begin
                start = (use_alt && p == 3 && k == 2);
                tick();
                chk($sformatf("p%0d k%0d gen_clk", p, k), int'(gen_clk), (k < H) ? 1 : 0);
                chk($sformatf("p%0d k%0d busy", p, k), int'(busy), 1);
                chk($sformatf("p%0d k%0d q hold", p, k), int'(q), int'(cur.exp_q));
                chk($sformatf("p%0d k%0d done", p, k), int'(done), 0);
                if (use_alt) d = (k == 2 * H - 1) ? nxt.d : ~d;
            end
            start = 1'b0;
            tick();
        end
        cur = tab(use_alt, N - 1);
        chk("end busy", int'(busy), 0);
        chk("end done", int'(done), 1);
        chk("end gen_clk", int'(gen_clk), 0);
        chk("end pulse_count", int'(pulse_count), N);
        chk("end q", int'(q), int'(cur.exp_q));
        tick();
        chk("after end done", int'(done), 0);
        chk("after end busy", int'(busy), 0);
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        stop   = 1'b0;
        d      = 1'b0;

        // d follows bit 1 of the period index: 0,0,1,1,0,0,1,1,0,0
        nom[0] = '{1'b0, 1'b0, 1};  nom[1] = '{1'b0, 1'b0, 2};
        nom[2] = '{1'b1, 1'b1, 3};  nom[3] = '{1'b1, 1'b1, 4};
        nom[4] = '{1'b0, 1'b0, 5};  nom[5] = '{1'b0, 1'b0, 6};
        nom[6] = '{1'b1, 1'b1, 7};  nom[7] = '{1'b1, 1'b1, 8};
        nom[8] = '{1'b0, 1'b0, 9};  nom[9] = '{1'b0, 1'b0, 10};
        alt[0] = '{1'b1, 1'b1, 1};  alt[1] = '{1'b0, 1'b0, 2};
        alt[2] = '{1'b1, 1'b1, 3};  alt[3] = '{1'b1, 1'b1, 4};
        alt[4] = '{1'b0, 1'b0, 5};  alt[5] = '{1'b1, 1'b1, 6};
        alt[6] = '{1'b0, 1'b0, 7};  alt[7] = '{1'b0, 1'b0, 8};
        alt[8] = '{1'b1, 1'b1, 9};  alt[9] = '{1'b0, 1'b0, 10};

        // Reset state
        tick();
        tick();
        chk("rst gen_clk", int'(gen_clk), 0);
        chk("rst q", int'(q), 0);
        chk("rst busy", int'(busy), 0);
        chk("rst done", int'(done), 0);
        chk("rst pulse_count", int'(pulse_count), 0);
        rst_n = 1'b1;
        tick();

        // Asynchronous reset with q=1 and gen_clk=1
        d     = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("pre-async gen_clk", int'(gen_clk), 1);
        chk("pre-async q", int'(q), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async gen_clk", int'(gen_clk), 0);
        chk("async q", int'(q), 0);
        chk("async busy", int'(busy), 0);
        chk("async pulse_count", int'(pulse_count), 0);
        tick();
        chk("held gen_clk", int'(gen_clk), 0);
        chk("held q", int'(q), 0);
        chk("held busy", int'(busy), 0);
        rst_n = 1'b1;
        tick();

        // Nominal burst, then burst with d toggling and a stray start
        run_burst(1'b0);
        tick();
        run_burst(1'b1);
        tick();

        // Abort during the 4th HIGH phase
        d     = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("abort rise1 q", int'(q), 1);
        repeat (4 * H) tick();
        chk("abort rise3 pulse_count", int'(pulse_count), 3);
        d = 1'b0;
        repeat (2 * H) tick();
        chk("abort rise4 pulse_count", int'(pulse_count), 4);
        chk("abort rise4 q", int'(q), 0);
        chk("abort rise4 gen_clk", int'(gen_clk), 1);
        d = 1'b1;
        tick();
        tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("abort gen_clk", int'(gen_clk), 0);
        chk("abort busy", int'(busy), 0);
        chk("abort pulse_count", int'(pulse_count), 4);
        chk("abort q", int'(q), 0);
        chk("abort done", int'(done), 0);
        for (int i = 0; i < 3 * H; i++) begin
            tick();
            chk($sformatf("post-abort%0d done", i), int'(done), 0);
            chk($sformatf("post-abort%0d gen_clk", i), int'(gen_clk), 0);
            chk($sformatf("post-abort%0d q", i), int'(q), 0);
        end

        // start and stop together in IDLE
        start = 1'b1;
        stop  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("ss%0d busy", i), int'(busy), 0);
            chk($sformatf("ss%0d gen_clk", i), int'(gen_clk), 0);
            chk($sformatf("ss%0d pulse_count", i), int'(pulse_count), 4);
        end
        start = 1'b0;
        stop  = 1'b0;
        tick();

        // Reset mid-burst at pulse 6, then a fresh burst
        d     = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10 * H) tick();
        chk("mid pulse_count", int'(pulse_count), 6);
        chk("mid busy", int'(busy), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid-rst pulse_count", int'(pulse_count), 0);
        chk("mid-rst busy", int'(busy), 0);
        chk("mid-rst gen_clk", int'(gen_clk), 0);
        tick();
        rst_n = 1'b1;
        tick();
        run_burst(1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
